// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcode and ALU op-code values,
// FSM state type and decoded control bundle.
package alu_sequencer_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 4;
  localparam int unsigned ALU_OC_WIDTH   = 3;
  localparam int unsigned OP_WIDTH       = 4;
  localparam int unsigned IMM_WIDTH      = 4;
  localparam int unsigned INSTR_WIDTH    = OP_WIDTH + IMM_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_LDA = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_LDB = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_OUT = 4'b0011;
  localparam logic                OP_ALU_PREFIX = 1'b1;

  localparam logic [ALU_OC_WIDTH-1:0] OC_ZERO = 3'b000;
  localparam logic [ALU_OC_WIDTH-1:0] OC_XOR  = 3'b001;
  localparam logic [ALU_OC_WIDTH-1:0] OC_AND  = 3'b010;
  localparam logic [ALU_OC_WIDTH-1:0] OC_OR   = 3'b011;
  localparam logic [ALU_OC_WIDTH-1:0] OC_ADD  = 3'b100;
  localparam logic [ALU_OC_WIDTH-1:0] OC_SUB  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic wr_acc;
    logic wr_b;
    logic use_alu;
    logic upd_c;
    logic illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decode: maps the latched opcode to register-write controls.
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [OP_WIDTH-1:0] op,
  output dec_ctrl_t           ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    if (op[OP_WIDTH-1] == OP_ALU_PREFIX) begin
      ctrl_c.wr_acc  = 1'b1;
      ctrl_c.use_alu = 1'b1;
      // Only arithmetic op-codes (oc[2]=1) produce a meaningful carry
      ctrl_c.upd_c   = op[2];
    end else begin
      case (op)
        OP_NOP, OP_OUT: begin
          ctrl_c = '0;
        end
        OP_LDA: ctrl_c.wr_acc = 1'b1;
        OP_LDB: ctrl_c.wr_b   = 1'b1;
        default: ctrl_c.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 4-bit ALU: holds ACC/B/C/Z, drives the external ALU
// and returns one registered response beat per accepted instruction.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned OC_WIDTH   = ALU_OC_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic [DATA_WIDTH-1:0]  alu_a_o,
  output logic [DATA_WIDTH-1:0]  alu_b_o,
  output logic [OC_WIDTH-1:0]    alu_oc_o,
  input  logic [DATA_WIDTH-1:0]  alu_result_i,
  input  logic                   alu_carry_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  rsp_acc_o,
  output logic                   rsp_c_o,
  output logic                   rsp_z_o,
  output logic                   rsp_illegal_o
);

  seq_state_e            state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [IMM_WIDTH-1:0]  imm_q, imm_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  c_q, c_d;
  logic                  z_q, z_d;
  logic                  instr_ready_d;
  logic [OC_WIDTH-1:0]   alu_oc_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_acc_d;
  logic                  rsp_c_d;
  logic                  rsp_z_d;
  logic                  rsp_illegal_d;
  dec_ctrl_t             ctrl_c;

  alu_seq_decode u_decode (
    .op     (op_q),
    .ctrl_c (ctrl_c)
  );

  assign alu_a_o = acc_q;
  assign alu_b_o = b_q;

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      imm_q         <= '0;
      acc_q         <= '0;
      b_q           <= '0;
      c_q           <= 1'b0;
      z_q           <= 1'b1;
      instr_ready_o <= 1'b1;
      alu_oc_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_acc_o     <= '0;
      rsp_c_o       <= 1'b0;
      rsp_z_o       <= 1'b1;
      rsp_illegal_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      imm_q         <= imm_d;
      acc_q         <= acc_d;
      b_q           <= b_d;
      c_q           <= c_d;
      z_q           <= z_d;
      instr_ready_o <= instr_ready_d;
      alu_oc_o      <= alu_oc_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_acc_o     <= rsp_acc_d;
      rsp_c_o       <= rsp_c_d;
      rsp_z_o       <= rsp_z_d;
      rsp_illegal_o <= rsp_illegal_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    imm_d         = imm_q;
    acc_d         = acc_q;
    b_d           = b_q;
    c_d           = c_q;
    z_d           = z_q;
    instr_ready_d = instr_ready_o;
    alu_oc_d      = '0;
    rsp_valid_d   = rsp_valid_o;
    rsp_acc_d     = rsp_acc_o;
    rsp_c_d       = rsp_c_o;
    rsp_z_d       = rsp_z_o;
    rsp_illegal_d = rsp_illegal_o;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid_i && instr_ready_o) begin
          op_d          = instr_i[INSTR_WIDTH-1:IMM_WIDTH];
          imm_d         = instr_i[IMM_WIDTH-1:0];
          instr_ready_d = 1'b0;
          state_d       = ST_EXEC;
          // Registered so the op-code is on the ALU for the whole EXEC cycle
          if (instr_i[INSTR_WIDTH-1] == OP_ALU_PREFIX) begin
            alu_oc_d = OC_WIDTH'(instr_i[IMM_WIDTH+2:IMM_WIDTH]);
          end
        end
      end
      ST_EXEC: begin
        if (ctrl_c.wr_acc) begin
          acc_d = ctrl_c.use_alu ? alu_result_i : DATA_WIDTH'(imm_q);
          z_d   = (acc_d == '0);
        end
        if (ctrl_c.wr_b) begin
          b_d = DATA_WIDTH'(imm_q);
        end
        if (ctrl_c.upd_c) begin
          c_d = alu_carry_i;
        end
        rsp_valid_d   = 1'b1;
        rsp_acc_d     = acc_d;
        rsp_c_d       = c_d;
        rsp_z_d       = z_d;
        rsp_illegal_d = ctrl_c.illegal;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d   = 1'b0;
          instr_ready_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
        rsp_valid_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 4-bit ALU beside it.
module tb_alu_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [7:0] instr_i;
  logic [3:0] alu_a_o;
  logic [3:0] alu_b_o;
  logic [2:0] alu_oc_o;
  logic [3:0] alu_result_i;
  logic       alu_carry_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [3:0] rsp_acc_o;
  logic       rsp_c_o;
  logic       rsp_z_o;
  logic       rsp_illegal_o;

  typedef struct packed {
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic       illegal;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0] acc_m;
  logic [3:0] b_m;
  logic       c_m;
  logic       z_m;
  int errors = 0;
  int checks = 0;
  logic [4:0] alu_sum;

  alu_sequencer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_oc_o      (alu_oc_o),
    .alu_result_i  (alu_result_i),
    .alu_carry_i   (alu_carry_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_acc_o     (rsp_acc_o),
    .rsp_c_o       (rsp_c_o),
    .rsp_z_o       (rsp_z_o),
    .rsp_illegal_o (rsp_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational ALU attached to the sequencer
  always_comb begin
    alu_sum      = 5'd0;
    alu_result_i = 4'd0;
    alu_carry_i  = 1'b0;
    case (alu_oc_o)
      3'b001: alu_result_i = alu_a_o ^ alu_b_o;
      3'b010: alu_result_i = alu_a_o & alu_b_o;
      3'b011: alu_result_i = alu_a_o | alu_b_o;
      3'b100, 3'b101: begin
        alu_sum      = {1'b0, alu_a_o} + {1'b0, alu_b_o};
        alu_result_i = alu_sum[3:0];
        alu_carry_i  = alu_sum[4];
      end
      3'b110, 3'b111: begin
        alu_sum      = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + 5'd1;
        alu_result_i = alu_sum[3:0];
        alu_carry_i  = alu_sum[4];
      end
      default: alu_result_i = 4'd0;
    endcase
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    acc_m = 4'd0;
    b_m   = 4'd0;
    c_m   = 1'b0;
    z_m   = 1'b1;
    exp_q.delete();
  endtask

  // Architectural model: computes the expected response and queues it
  task automatic model_push(input logic [7:0] ins);
    logic [3:0] op;
    logic [3:0] imm;
    logic [4:0] s;
    exp_t e;
    op = ins[7:4];
    imm = ins[3:0];
    e.illegal = 1'b0;
    if (op[3]) begin
      case (op[2:0])
        3'b000: acc_m = 4'd0;
        3'b001: acc_m = acc_m ^ b_m;
        3'b010: acc_m = acc_m & b_m;
        3'b011: acc_m = acc_m | b_m;
        3'b100, 3'b101: begin
          s = {1'b0, acc_m} + {1'b0, b_m};
          acc_m = s[3:0];
          c_m = s[4];
        end
        default: begin
          c_m = (acc_m >= b_m);
          acc_m = acc_m - b_m;
        end
      endcase
      z_m = (acc_m == 4'd0);
    end else if (op == 4'd1) begin
      acc_m = imm;
      z_m = (imm == 4'd0);
    end else if (op == 4'd2) begin
      b_m = imm;
    end else if (op[2]) begin
      e.illegal = 1'b1;
    end
    e.acc = acc_m;
    e.c = c_m;
    e.z = z_m;
    exp_q.push_back(e);
  endtask

  // Offer one instruction; returns #1 after the handshake edge (DUT in EXEC)
  task automatic issue(input logic [7:0] ins);
    int n;
    n = 0;
    instr_i = ins;
    instr_valid_i = 1'b1;
    while (instr_ready_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (instr_ready_o !== 1'b1) check_val("issue_ready_timeout", 8'(instr_ready_o), 8'd1);
    model_push(ins);
    step();
    instr_valid_i = 1'b0;
  endtask

  // Wait for a response beat, compare against the scoreboard head, let it be accepted
  task automatic expect_rsp(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (rsp_valid_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (rsp_valid_o !== 1'b1) begin
      check_val({tag, "_rsp_timeout"}, 8'(rsp_valid_o), 8'd1);
    end else if (exp_q.size() == 0) begin
      check_val({tag, "_unexpected_rsp"}, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_acc"}, 8'(rsp_acc_o), 8'(e.acc));
      check_val({tag, "_c"}, 8'(rsp_c_o), 8'(e.c));
      check_val({tag, "_z"}, 8'(rsp_z_o), 8'(e.z));
      check_val({tag, "_illegal"}, 8'(rsp_illegal_o), 8'(e.illegal));
    end
    step();
  endtask

  task automatic run(input logic [7:0] ins, input string tag);
    issue(ins);
    expect_rsp(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_alu_a"}, 8'(alu_a_o), 8'd0);
    check_val({tag, "_alu_b"}, 8'(alu_b_o), 8'd0);
    check_val({tag, "_alu_oc"}, 8'(alu_oc_o), 8'd0);
    check_val({tag, "_ready"}, 8'(instr_ready_o), 8'd1);
    check_val({tag, "_rsp_valid"}, 8'(rsp_valid_o), 8'd0);
    check_val({tag, "_rsp_illegal"}, 8'(rsp_illegal_o), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    instr_valid_i = 1'b0;
    instr_i = 8'h00;
    rsp_ready_i = 1'b1;
    model_reset();

    // Reset state
    repeat (3) step();
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    step();
    run(8'h30, "reset_out");

    // LDA 5, LDB 3, ADD with latency check
    run(8'h15, "lda5");
    run(8'h23, "ldb3");
    issue(8'hC0);
    check_val("lat_exec_valid", 8'(rsp_valid_o), 8'd0);
    check_val("exec_oc_add", 8'(alu_oc_o), 8'h4);
    check_val("exec_ready", 8'(instr_ready_o), 8'd0);
    step();
    check_val("lat_resp_valid", 8'(rsp_valid_o), 8'd1);
    check_val("resp_oc_zero", 8'(alu_oc_o), 8'd0);
    expect_rsp("add_5_3");

    // SUB to zero and ADD wrap-around
    run(8'h13, "lda3");
    run(8'h23, "ldb3b");
    run(8'hE0, "sub_3_3");
    run(8'h1F, "ldaf");
    run(8'h21, "ldb1");
    run(8'hC0, "add_f_1");

    // Logic ops keep C; zero op; borrow case
    run(8'h16, "lda6");
    run(8'h23, "ldb3c");
    run(8'h90, "xor_6_3");
    run(8'hA0, "and_5_3");
    run(8'hB0, "or_1_3");
    run(8'h80, "oc_zero");
    run(8'h12, "lda2");
    run(8'h25, "ldb5");
    run(8'hE0, "sub_2_5");
    run(8'hD0, "sub_oc101_alias");

    // Backpressure: payload held, second instruction not taken
    rsp_ready_i = 1'b0;
    issue(8'h19);
    instr_i = 8'h12;
    instr_valid_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check_val("bp_valid", 8'(rsp_valid_o), 8'd1);
      check_val("bp_acc", 8'(rsp_acc_o), 8'h9);
      check_val("bp_ready", 8'(instr_ready_o), 8'd0);
      step();
    end
    instr_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    expect_rsp("bp_lda9");
    run(8'h30, "bp_out");

    // Reserved opcode after LDA 7, then NOP clears illegal
    run(8'h17, "lda7");
    run(8'h50, "reserved_0101");
    run(8'h7A, "reserved_0111");
    run(8'h00, "nop_after_illegal");

    // Reset during EXEC of an ADD
    run(8'h15, "pre_rst_lda5");
    run(8'h23, "pre_rst_ldb3");
    issue(8'hC0);
    check_val("rst_exec_oc", 8'(alu_oc_o), 8'h4);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_no_rsp", 8'(rsp_valid_o), 8'd0);
    end
    rst_ni = 1'b1;
    step();
    check_val("post_rst_no_rsp", 8'(rsp_valid_o), 8'd0);
    run(8'h30, "post_rst_out");
    run(8'h8F, "post_rst_zero_op");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
